// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
// Top-level sequencing for a flappy-bird style game: button conditioning,
// game-tick generation, game state machine and score keeping.
//
// Parameters
//   TICK_DIV    clk cycles per game tick
//   DEAD_TICKS  game ticks spent in DEAD before moving to OVER
//   LOCKOUT     clk cycles during which further button presses are ignored
//
// Ports
//   clk          system clock, all logic on the rising edge
//   clr          asynchronous active-high reset
//   flap_btn     raw asynchronous button level, 1 = pressed
//   crash        crash detector level, 1 = bird overlaps tube or bounds
//   tube_passed  single-cycle pulse when the bird clears a tube
//   tick         single-cycle game-tick enable for the datapath
//   run_en       1 only while playing
//   flap         single-cycle debounced flap pulse, only while playing
//   world_reset  single-cycle pulse re-initialising bird and tube positions
//   game_end     1 in DEAD and OVER
//   state        IDLE=00, PLAY=01, DEAD=10, OVER=11
//   score        current-game score (saturates at 255)
//   high_score   best score since reset
// -----------------------------------------------------------------------------
module game_controller #(
    parameter int TICK_DIV   = 5000000,
    parameter int DEAD_TICKS = 20,
    parameter int LOCKOUT    = 500000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       flap_btn,
    input  logic       crash,
    input  logic       tube_passed,
    output logic       tick,
    output logic       run_en,
    output logic       flap,
    output logic       world_reset,
    output logic       game_end,
    output logic [1:0] state,
    output logic [7:0] score,
    output logic [7:0] high_score
);

    localparam int DIV_W  = (TICK_DIV > 1)   ? $clog2(TICK_DIV)       : 1;
    localparam int DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;
    localparam int LOCK_W = (LOCKOUT > 1)    ? $clog2(LOCKOUT + 1)    : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_PRE    = DIV_W'(TICK_DIV - 2);
    localparam logic [DEAD_W-1:0] DEAD_LAST  = DEAD_W'(DEAD_TICKS - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCKOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    logic              sync1_r, sync2_r, sync3_r;
    logic [LOCK_W-1:0] lock_cnt_r;
    logic              press_s;
    logic [DIV_W-1:0]  div_r;
    logic              tick_r;
    state_t            state_r, state_next_s;
    logic [7:0]        score_r, score_next_s;
    logic [7:0]        high_r, high_next_s;
    logic [DEAD_W-1:0] dead_cnt_r, dead_next_s;
    logic              world_reset_r, wr_next_s;
    logic              flap_r, flap_next_s;
    logic              run_en_r, game_end_r;

    // A press is a rising edge of the synchronised level outside the lockout window.
    assign press_s = sync2_r & ~sync3_r & (lock_cnt_r == {LOCK_W{1'b0}});

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= flap_btn;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Lockout counter: reloaded on every accepted press, counts down to zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            lock_cnt_r <= {LOCK_W{1'b0}};
        end else if (press_s) begin
            lock_cnt_r <= LOCK_LOAD;
        end else if (lock_cnt_r != {LOCK_W{1'b0}}) begin
            lock_cnt_r <= lock_cnt_r - {{(LOCK_W-1){1'b0}}, 1'b1};
        end else begin
            lock_cnt_r <= lock_cnt_r;
        end
    end

    // Free-running tick divider; tick_r is set one cycle early so it is high
    // exactly while the count sits at its last value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            div_r  <= (div_r == DIV_LAST) ? {DIV_W{1'b0}} : div_r + {{(DIV_W-1){1'b0}}, 1'b1};
            tick_r <= (div_r == DIV_PRE);
        end
    end

    // Next-state, score and pulse decode for the game state machine.
    always_comb begin
        state_next_s = state_r;
        score_next_s = score_r;
        high_next_s  = high_r;
        dead_next_s  = dead_cnt_r;
        wr_next_s    = 1'b0;
        flap_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (press_s) begin
                    state_next_s = ST_PLAY;
                    score_next_s = 8'd0;
                    wr_next_s    = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                flap_next_s = press_s;
                // Crash has priority over a simultaneous tube pass.
                if (crash) begin
                    state_next_s = ST_DEAD;
                    dead_next_s  = {DEAD_W{1'b0}};
                    if (score_r > high_r) begin
                        high_next_s = score_r;
                    end else begin
                        high_next_s = high_r;
                    end
                end else if (tube_passed) begin
                    score_next_s = (score_r == 8'hFF) ? 8'hFF : score_r + 8'd1;
                end else begin
                    score_next_s = score_r;
                end
            end
            ST_DEAD: begin
                if (tick_r) begin
                    if (dead_cnt_r == DEAD_LAST) begin
                        state_next_s = ST_OVER;
                    end else begin
                        dead_next_s = dead_cnt_r + {{(DEAD_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    dead_next_s = dead_cnt_r;
                end
            end
            ST_OVER: begin
                if (press_s) begin
                    state_next_s = ST_IDLE;
                    wr_next_s    = 1'b1;
                end else begin
                    state_next_s = ST_OVER;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, score and registered output decode.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r       <= ST_IDLE;
            score_r       <= 8'd0;
            high_r        <= 8'd0;
            dead_cnt_r    <= {DEAD_W{1'b0}};
            world_reset_r <= 1'b0;
            flap_r        <= 1'b0;
            run_en_r      <= 1'b0;
            game_end_r    <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            score_r       <= score_next_s;
            high_r        <= high_next_s;
            dead_cnt_r    <= dead_next_s;
            world_reset_r <= wr_next_s;
            flap_r        <= flap_next_s;
            // Decoded from the next state so they always match state_r.
            run_en_r      <= (state_next_s == ST_PLAY);
            game_end_r    <= (state_next_s == ST_DEAD) || (state_next_s == ST_OVER);
        end
    end

    assign tick        = tick_r;
    assign run_en      = run_en_r;
    assign flap        = flap_r;
    assign world_reset = world_reset_r;
    assign game_end    = game_end_r;
    assign state       = state_r;
    assign score       = score_r;
    assign high_score  = high_r;

endmodule

// File: tb/tb_game_controller.sv
// -----------------------------------------------------------------------------
// tb_game_controller
// Directed, table-driven bench for game_controller with small parameters
// (TICK_DIV=10, DEAD_TICKS=3, LOCKOUT=8). Each table row holds inputs, a
// cycle count and the expected outputs / pulse counts after that many cycles.
// -----------------------------------------------------------------------------
module tb_game_controller;

    logic       clk;
    logic       clr;
    logic       flap_btn;
    logic       crash;
    logic       tube_passed;
    logic       tick;
    logic       run_en;
    logic       flap;
    logic       world_reset;
    logic       game_end;
    logic [1:0] state;
    logic [7:0] score;
    logic [7:0] high_score;

    int checks;
    int failures;
    int wr_cnt;
    int fl_cnt;

    game_controller #(
        .TICK_DIV  (10),
        .DEAD_TICKS(3),
        .LOCKOUT   (8)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .flap_btn   (flap_btn),
        .crash      (crash),
        .tube_passed(tube_passed),
        .tick       (tick),
        .run_en     (run_en),
        .flap       (flap),
        .world_reset(world_reset),
        .game_end   (game_end),
        .state      (state),
        .score      (score),
        .high_score (high_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        logic       crash_in;
        logic       tube;
        int         cycles;
        logic [1:0] st;
        logic [7:0] sc;
        logic [7:0] hs;
        logic       ge;
        logic       re;
        int         wr;
        int         fl;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges, counting world_reset / flap pulses just after each edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (world_reset === 1'b1) wr_cnt++;
            if (flap === 1'b1) fl_cnt++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_score"}, 32'(score), 32'd0);
        chk({tag, "_high"}, 32'(high_score), 32'd0);
        chk({tag, "_tick"}, 32'(tick), 32'd0);
        chk({tag, "_flap"}, 32'(flap), 32'd0);
        chk({tag, "_wr"}, 32'(world_reset), 32'd0);
        chk({tag, "_run_en"}, 32'(run_en), 32'd0);
        chk({tag, "_game_end"}, 32'(game_end), 32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        wr_cnt      = 0;
        fl_cnt      = 0;
        clr         = 1'b1;
        flap_btn    = 1'b0;
        crash       = 1'b0;
        tube_passed = 1'b0;

        //          btn   crash tube  cyc st     sc     hs    ge    re    wr fl
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 20, 2'd1, 8'd0, 8'd0, 1'b0, 1'b1, 1, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 12, 2'd1, 8'd0, 8'd0, 1'b0, 1'b1, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1,  1, 2'd1, 8'd1, 8'd0, 1'b0, 1'b1, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0,  2, 2'd1, 8'd1, 8'd0, 1'b0, 1'b1, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1,  1, 2'd1, 8'd2, 8'd0, 1'b0, 1'b1, 0, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0,  1, 2'd1, 8'd2, 8'd0, 1'b0, 1'b1, 0, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1,  1, 2'd1, 8'd3, 8'd0, 1'b0, 1'b1, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0,  1, 2'd1, 8'd3, 8'd0, 1'b0, 1'b1, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1,  1, 2'd2, 8'd3, 8'd3, 1'b1, 1'b0, 0, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0,  5, 2'd2, 8'd3, 8'd3, 1'b1, 1'b0, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 40, 2'd3, 8'd3, 8'd3, 1'b1, 1'b0, 0, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0,  5, 2'd0, 8'd3, 8'd3, 1'b0, 1'b0, 1, 0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 12, 2'd0, 8'd3, 8'd3, 1'b0, 1'b0, 0, 0};
        vecs[13] = '{1'b1, 1'b0, 1'b0,  5, 2'd1, 8'd0, 8'd3, 1'b0, 1'b1, 1, 0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 12, 2'd1, 8'd0, 8'd3, 1'b0, 1'b1, 0, 0};
        vecs[15] = '{1'b0, 1'b0, 1'b1,  1, 2'd1, 8'd1, 8'd3, 1'b0, 1'b1, 0, 0};
        vecs[16] = '{1'b0, 1'b0, 1'b0,  1, 2'd1, 8'd1, 8'd3, 1'b0, 1'b1, 0, 0};
        vecs[17] = '{1'b0, 1'b0, 1'b1,  1, 2'd1, 8'd2, 8'd3, 1'b0, 1'b1, 0, 0};
        vecs[18] = '{1'b0, 1'b0, 1'b0,  1, 2'd1, 8'd2, 8'd3, 1'b0, 1'b1, 0, 0};
        vecs[19] = '{1'b0, 1'b1, 1'b0,  1, 2'd2, 8'd2, 8'd3, 1'b1, 1'b0, 0, 0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 40, 2'd3, 8'd2, 8'd3, 1'b1, 1'b0, 0, 0};
        vecs[21] = '{1'b1, 1'b0, 1'b0,  5, 2'd0, 8'd2, 8'd3, 1'b0, 1'b0, 1, 0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 12, 2'd0, 8'd2, 8'd3, 1'b0, 1'b0, 0, 0};
        vecs[23] = '{1'b1, 1'b0, 1'b0,  5, 2'd1, 8'd0, 8'd3, 1'b0, 1'b1, 1, 0};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 12, 2'd1, 8'd0, 8'd3, 1'b0, 1'b1, 0, 0};

        // Reset values while clr is held.
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");

        // Tick spacing after release: cycle 1 starts at release.
        clr = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            #1;
            chk($sformatf("tick_c%0d", c), 32'(tick), ((c % 10) == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("idle_after_ticks", 32'(state), 32'd0);

        // Table-driven game sequence.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            flap_btn    = vecs[i].btn;
            crash       = vecs[i].crash_in;
            tube_passed = vecs[i].tube;
            wr_cnt      = 0;
            fl_cnt      = 0;
            step(vecs[i].cycles);
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d_score", i), 32'(score), 32'(vecs[i].sc));
            chk($sformatf("v%0d_high", i), 32'(high_score), 32'(vecs[i].hs));
            chk($sformatf("v%0d_game_end", i), 32'(game_end), 32'(vecs[i].ge));
            chk($sformatf("v%0d_run_en", i), 32'(run_en), 32'(vecs[i].re));
            chk($sformatf("v%0d_wr_pulses", i), 32'(wr_cnt), 32'(vecs[i].wr));
            chk($sformatf("v%0d_flap_pulses", i), 32'(fl_cnt), 32'(vecs[i].fl));
        end

        // 300 tube passes in PLAY saturate the score.
        @(negedge clk);
        flap_btn    = 1'b0;
        crash       = 1'b0;
        tube_passed = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            tube_passed = 1'b1;
            step(1);
            @(negedge clk);
            tube_passed = 1'b0;
            step(1);
        end
        chk("sat_score", 32'(score), 32'd255);
        chk("sat_state", 32'(state), 32'd1);

        // Two presses four cycles apart fall inside one lockout window.
        wr_cnt = 0;
        fl_cnt = 0;
        @(negedge clk);
        flap_btn = 1'b1;
        step(2);
        @(negedge clk);
        flap_btn = 1'b0;
        step(2);
        @(negedge clk);
        flap_btn = 1'b1;
        step(2);
        @(negedge clk);
        flap_btn = 1'b0;
        step(20);
        chk("lockout_flap_pulses", 32'(fl_cnt), 32'd1);
        chk("lockout_wr_pulses", 32'(wr_cnt), 32'd0);
        chk("lockout_state", 32'(state), 32'd1);

        // Second press well after the lockout produces another flap.
        fl_cnt = 0;
        @(negedge clk);
        flap_btn = 1'b1;
        step(6);
        @(negedge clk);
        flap_btn = 1'b0;
        step(4);
        chk("flap_again_pulses", 32'(fl_cnt), 32'd1);

        // clr mid-PLAY takes effect immediately, high_score included.
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk_reset_outputs("clr_mid");
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        step(3);
        chk("post_clr_state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
